// File: rtl/serial_tx_fsm.sv
// serial_tx_fsm: frame-based serial transmitter.
// Frame = start bit (0), WIDTH data bits LSB-first, stop bit (1).
// Every bit is held on tx for CLKS_PER_BIT clocks. All outputs are registered.
module serial_tx_fsm #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  // Counter widths, at least one bit even for degenerate ranges.
  localparam int unsigned TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Index of the bit that becomes the LSB after one right shift.
  localparam int unsigned NEXT_LSB = (WIDTH > 1) ? 1 : 0;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  shreg;
  logic [TICK_W-1:0] tick;
  logic [BIT_W-1:0]  bit_cnt;

  // Frame sequencer: state, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      tick    <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (start) begin
            shreg   <= din;
            tick    <= '0;
            bit_cnt <= '0;
            state   <= START;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end
        end

        START: begin
          if (tick == TICK_LAST) begin
            tick  <= '0;
            state <= DATA;
            tx    <= shreg[0];
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end

        DATA: begin
          if (tick == TICK_LAST) begin
            tick <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              // Drive the bit that the shift is about to expose.
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + BIT_W'(1);
              tx      <= shreg[NEXT_LSB];
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end

        STOP: begin
          if (tick == TICK_LAST) begin
            tick  <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_fsm.sv
// Directed testbench for serial_tx_fsm (8-bit/4-clock instance plus a 4-bit/1-clock instance).
module tb_serial_tx_fsm;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic       tx;
  logic       busy;
  logic       done;

  logic       rst1;
  logic       start1;
  logic [3:0] din1;
  logic       tx1;
  logic       busy1;
  logic       done1;

  int vectors;
  int errors;

  serial_tx_fsm #(.WIDTH(8), .CLKS_PER_BIT(4)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  serial_tx_fsm #(.WIDTH(4), .CLKS_PER_BIT(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst1),
    .start (start1),
    .din   (din1),
    .tx    (tx1),
    .busy  (busy1),
    .done  (done1)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; drive and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = i[0]; din = (i == 1) ? 8'h5A : 8'hC3;
      start1 = i[0]; din1 = 4'hF;
      tick();
      vectors++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got tx=%b busy=%b done=%b need 1 0 0", i, tx, busy, done);
      end
      vectors++;
      if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold1 cyc=%0d got tx=%b busy=%b done=%b need 1 0 0", i, tx1, busy1, done1);
      end
    end
    start = 1'b0; start1 = 1'b0;
    rst = 1'b0; rst1 = 1'b0;
    tick();
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got tx=%b busy=%b done=%b need 1 0 0", tx, busy, done);
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] seq;
    seq = 10'b11_0100_1010; // bits 0..9 = 0,1,0,1,0,0,1,0,1,1
    din = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      vectors++;
      if (tx !== seq[n/4] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL a5_frame n=%0d got tx=%b busy=%b done=%b need %b 1 0", n, tx, busy, done, seq[n/4]);
      end
      tick();
    end
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL a5_done_e40 got tx=%b busy=%b done=%b need 1 0 1", tx, busy, done);
    end
    tick();
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL a5_after_done got tx=%b busy=%b done=%b need 1 0 0", tx, busy, done);
    end
  endtask

  task automatic test_ignored_start();
    logic [9:0] seq;
    seq = 10'b11_0100_1010;
    din = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (n == 11) begin start = 1'b1; din = 8'h3C; end
      if (n == 12) start = 1'b0;
      vectors++;
      if (tx !== seq[n/4] || busy !== 1'b1) begin
        errors++;
        $display("FAIL ignored_start n=%0d got tx=%b busy=%b need %b 1", n, tx, busy, seq[n/4]);
      end
      tick();
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_done got done=%b busy=%b need 1 0", done, busy);
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      vectors++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL no_second_frame n=%0d got tx=%b busy=%b done=%b need 1 0 0", n, tx, busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] seq_a;
    logic [9:0] seq_b;
    seq_a = 10'b10_0000_0010; // 0,1,0,0,0,0,0,0,0,1
    seq_b = 10'b11_1111_1110; // 0,1,1,1,1,1,1,1,1,1
    din = 8'h01; start = 1'b1;
    tick();
    for (int n = 0; n < 40; n++) begin
      vectors++;
      if (tx !== seq_a[n/4] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_first n=%0d got tx=%b busy=%b done=%b need %b 1 0", n, tx, busy, done, seq_a[n/4]);
      end
      tick();
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done1 got tx=%b busy=%b done=%b need 1 0 1", tx, busy, done);
    end
    din = 8'hFF;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      vectors++;
      if (tx !== seq_b[n/4] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_second n=%0d got tx=%b busy=%b done=%b need %b 1 0", n, tx, busy, done, seq_b[n/4]);
      end
      tick();
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done2 got tx=%b busy=%b done=%b need 1 0 1", tx, busy, done);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got busy=%b done=%b need 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] seq_a;
    logic [9:0] seq_b;
    seq_a = 10'b11_0100_1010;
    seq_b = 10'b10_1011_0100; // 0,0,1,0,1,1,0,1,0,1
    din = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 18; n++) begin
      vectors++;
      if (tx !== seq_a[n/4] || busy !== 1'b1) begin
        errors++;
        $display("FAIL mid_pre n=%0d got tx=%b busy=%b need %b 1", n, tx, busy, seq_a[n/4]);
      end
      if (n == 17) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got tx=%b busy=%b done=%b need 1 0 0", tx, busy, done);
    end
    for (int n = 0; n < 30; n++) begin
      tick();
      vectors++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL mid_quiet n=%0d got tx=%b busy=%b done=%b need 1 0 0", n, tx, busy, done);
      end
    end
    din = 8'h5A; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      vectors++;
      if (tx !== seq_b[n/4] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL mid_5a n=%0d got tx=%b busy=%b done=%b need %b 1 0", n, tx, busy, done, seq_b[n/4]);
      end
      tick();
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL mid_5a_done got tx=%b busy=%b done=%b need 1 0 1", tx, busy, done);
    end
    tick();
  endtask

  task automatic test_one_clk_per_bit();
    logic [5:0] seq;
    seq = 6'b11_0010; // 0,1,0,0,1,1
    din1 = 4'b1001; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int n = 0; n < 6; n++) begin
      vectors++;
      if (tx1 !== seq[n] || busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL cpb1 n=%0d got tx=%b busy=%b done=%b need %b 1 0", n, tx1, busy1, done1, seq[n]);
      end
      tick();
    end
    vectors++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || tx1 !== 1'b1) begin
      errors++;
      $display("FAIL cpb1_done got tx=%b busy=%b done=%b need 1 0 1", tx1, busy1, done1);
    end
    tick();
    vectors++;
    if (done1 !== 1'b0 || busy1 !== 1'b0 || tx1 !== 1'b1) begin
      errors++;
      $display("FAIL cpb1_idle got tx=%b busy=%b done=%b need 1 0 0", tx1, busy1, done1);
    end
  endtask

  initial begin
    clk = 1'b0;
    vectors = 0; errors = 0;
    rst = 1'b1; start = 1'b0; din = '0;
    rst1 = 1'b1; start1 = 1'b0; din1 = '0;
    #1;
    test_reset();
    test_single_frame();
    tick();
    test_ignored_start();
    tick();
    test_back_to_back();
    tick();
    test_reset_mid_frame();
    tick();
    test_one_clk_per_bit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
